// File: rtl/mem_stage_if.sv
// Execute-to-memory-stage bus: execute outputs, data-memory handshake and writeback/forwarding outputs.
interface mem_stage_if;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 14;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 5;

  logic [CW-1:0] control_in;
  logic [DW-1:0] result_in;
  logic [DW-1:0] addr_in;
  logic [IW-1:0] dest_index_in;
  logic          write_en_in;
  logic [AW-1:0] target_in;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          stall;
  logic [CW-1:0] wb_control;
  logic [DW-1:0] wb_data;
  logic [IW-1:0] wb_dest;
  logic          wb_we;
  logic [AW-1:0] target_out;
  logic          mem_error;

  modport slave (
    input  control_in, result_in, addr_in, dest_index_in, write_en_in, target_in,
           mem_rdata, mem_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, stall, wb_control, wb_data,
           wb_dest, wb_we, target_out, mem_error
  );

  modport master (
    output control_in, result_in, addr_in, dest_index_in, write_en_in, target_in,
           mem_rdata, mem_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall, wb_control, wb_data,
           wb_dest, wb_we, target_out, mem_error
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues LOAD/STORE over a req/ready handshake, stalls upstream
// while waiting, and turns a memory that never answers into a sticky error.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_stage_if.slave bus
);
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 14;
  localparam int unsigned CW   = 4;
  localparam int unsigned IW   = 5;
  localparam int unsigned CNTW = 8;

  localparam logic [CW-1:0]   OP_NOP    = 4'b0000;
  localparam logic [CW-1:0]   OP_LOAD   = 4'b1100;
  localparam logic [CW-1:0]   OP_STORE  = 4'b1110;
  localparam logic [CNTW-1:0] TIMEOUT_C = CNTW'(TIMEOUT);

  typedef enum logic {IDLE, REQ} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [IW-1:0]   dest_q, dest_d;
  logic [CW-1:0]   wb_control_q, wb_control_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic [IW-1:0]   wb_dest_q, wb_dest_d;
  logic            wb_we_q, wb_we_d;
  logic [AW-1:0]   target_q, target_d;
  logic            err_q, err_d;
  logic            is_mem_c;
  logic            stall_c;
  logic [1:0]      unused_addr_hi;

  assign unused_addr_hi = bus.addr_in[DW-1:AW];

  // Next-state and output decode; mem_we_q doubles as the latched op of the outstanding access.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    dest_d       = dest_q;
    wb_control_d = wb_control_q;
    wb_data_d    = wb_data_q;
    wb_dest_d    = wb_dest_q;
    wb_we_d      = wb_we_q;
    target_d     = target_q;
    err_d        = err_q;
    stall_c      = 1'b0;
    is_mem_c     = (bus.control_in == OP_LOAD) || (bus.control_in == OP_STORE);

    case (state_q)
      IDLE: begin
        target_d = bus.target_in;
        if (is_mem_c) begin
          stall_c      = 1'b1;
          mem_req_d    = 1'b1;
          mem_we_d     = (bus.control_in == OP_STORE);
          mem_addr_d   = bus.addr_in[AW-1:0];
          mem_wdata_d  = bus.result_in;
          dest_d       = bus.dest_index_in;
          cnt_d        = '0;
          wb_control_d = OP_NOP;
          wb_data_d    = '0;
          wb_we_d      = 1'b0;
          state_d      = REQ;
        end else begin
          wb_control_d = bus.control_in;
          wb_data_d    = bus.result_in;
          wb_dest_d    = bus.dest_index_in;
          wb_we_d      = bus.write_en_in;
        end
      end
      REQ: begin
        stall_c = !bus.mem_ready && (cnt_q != TIMEOUT_C);
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wb_dest_d = dest_q;
          state_d   = IDLE;
          if (mem_we_q) begin
            wb_control_d = OP_STORE;
            wb_data_d    = mem_wdata_q;
            wb_we_d      = 1'b0;
          end else begin
            wb_control_d = OP_LOAD;
            wb_data_d    = bus.mem_rdata;
            wb_we_d      = 1'b1;
          end
        end else if (cnt_q != TIMEOUT_C) begin
          cnt_d = cnt_q + CNTW'(1);
        end else begin
          // Memory never answered: abort with a bubble and latch the error.
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          err_d        = 1'b1;
          wb_control_d = OP_NOP;
          wb_data_d    = '0;
          wb_we_d      = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      dest_q       <= '0;
      wb_control_q <= '0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      wb_we_q      <= 1'b0;
      target_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      dest_q       <= dest_d;
      wb_control_q <= wb_control_d;
      wb_data_q    <= wb_data_d;
      wb_dest_q    <= wb_dest_d;
      wb_we_q      <= wb_we_d;
      target_q     <= target_d;
      err_q        <= err_d;
    end
  end

  // Stall is forced low while reset is held so upstream is never frozen by a stale opcode.
  assign bus.stall      = rst_n & stall_c;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.wb_control = wb_control_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_dest    = wb_dest_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.target_out = target_q;
  assign bus.mem_error  = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver plays upstream and memory, a monitor checks each
// completed instruction against the reference model's expected writeback and handshake shape.
module tb_mem_stage;
  localparam int unsigned TO = 15;
  localparam logic [3:0] NOP = 4'b0000, ADD = 4'b0001, LOAD = 4'b1100, STORE = 4'b1110;
  localparam int NEVER = 1000;

  typedef struct {
    logic [3:0]  ctrl;
    logic [15:0] data;
    logic        we;
    logic        chk_dest;
    logic [4:0]  dest;
    logic        err;
    int          stalls;
    int          reqs;
    logic        mem_we;
    logic [13:0] addr;
    logic [15:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  mem_stage_if bus();

  mem_stage #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic stall_s = 1'b0;
  int   stall_cnt = 0;
  int   req_cnt = 0;
  logic err_model = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the expected outcome of one instruction, from the stage's rules.
  task automatic run(input logic [3:0] op, input logic [15:0] res, input logic [15:0] addr,
                     input logic [4:0] dest, input logic we, input int rdy_at,
                     input logic [15:0] rdata);
    exp_t e;
    bit   is_mem;
    bit   done;
    int   reqc;
    is_mem     = (op == LOAD) || (op == STORE);
    e.mem_we   = (op == STORE);
    e.addr     = addr[13:0];
    e.wdata    = res;
    e.dest     = dest;
    e.chk_dest = 1'b0;
    if (!is_mem) begin
      e.ctrl = op; e.data = res; e.we = we; e.chk_dest = 1'b1; e.stalls = 0; e.reqs = 0;
    end else if (rdy_at <= int'(TO)) begin
      e.stalls = rdy_at + 1;
      e.reqs   = rdy_at + 1;
      if (op == LOAD) begin
        e.ctrl = LOAD; e.data = rdata; e.we = 1'b1; e.chk_dest = 1'b1;
      end else begin
        e.ctrl = STORE; e.data = res; e.we = 1'b0;
      end
    end else begin
      e.stalls = int'(TO) + 1; e.reqs = int'(TO) + 1;
      e.ctrl = NOP; e.data = 16'h0000; e.we = 1'b0;
      err_model = 1'b1;
    end
    e.err = err_model;
    sb.push_back(e);

    @(negedge clk);
    bus.control_in    = op;
    bus.result_in     = res;
    bus.addr_in       = addr;
    bus.dest_index_in = dest;
    bus.write_en_in   = we;
    bus.target_in     = 14'($urandom);
    mon_en = 1'b1;
    reqc = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.mem_req) begin
        // Inputs are don't-care while an access is outstanding.
        bus.control_in    = 4'($urandom);
        bus.result_in     = 16'($urandom);
        bus.addr_in       = 16'($urandom);
        bus.dest_index_in = 5'($urandom);
        bus.mem_ready     = (reqc == rdy_at);
        bus.mem_rdata     = (reqc == rdy_at) ? rdata : 16'($urandom);
        reqc++;
      end else begin
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = 16'($urandom);
      end
      #1;
      if (!bus.stall) done = 1'b1;
    end
    if (!done) chk("op_completes_in_bound", 32'd0, 32'd1);
  endtask

  // Monitor: every edge taken with stall low retires the oldest scoreboard entry.
  initial begin
    forever begin
      @(negedge clk); #2;
      stall_s = bus.stall;
      @(posedge clk); #1;
      if (mon_en && rst_n) begin
        if (stall_s) stall_cnt++;
        if (bus.mem_req) begin
          req_cnt++;
          if (sb.size() == 0) chk("req_without_op", 32'd0, 32'd1);
          else begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
            chk("mem_we", 32'(bus.mem_we), 32'(sb[0].mem_we));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
          end
        end
        if (!stall_s) begin
          if (sb.size() == 0) chk("retire_without_op", 32'd0, 32'd1);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_control", 32'(bus.wb_control), 32'(e.ctrl));
            chk("wb_data", 32'(bus.wb_data), 32'(e.data));
            chk("wb_we", 32'(bus.wb_we), 32'(e.we));
            if (e.chk_dest) chk("wb_dest", 32'(bus.wb_dest), 32'(e.dest));
            chk("mem_error", 32'(bus.mem_error), 32'(e.err));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            chk("req_cycles", 32'(req_cnt), 32'(e.reqs));
            chk("req_low_after", 32'(bus.mem_req), 32'd0);
          end
          stall_cnt = 0;
          req_cnt   = 0;
        end
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] tgt;
    int          sel;
    int          rdy;

    rst_n             = 1'b0;
    bus.control_in    = LOAD;
    bus.result_in     = 16'hFFFF;
    bus.addr_in       = 16'hFFFF;
    bus.dest_index_in = 5'h1F;
    bus.write_en_in   = 1'b1;
    bus.target_in     = 14'h3FFF;
    bus.mem_rdata     = 16'hFFFF;
    bus.mem_ready     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_wb_control", 32'(bus.wb_control), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
    chk("rst_wb_dest", 32'(bus.wb_dest), 32'd0);
    chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
    chk("rst_target_out", 32'(bus.target_out), 32'd0);
    chk("rst_mem_error", 32'(bus.mem_error), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.control_in = NOP;
    bus.mem_ready  = 1'b0;
    repeat (2) @(negedge clk);

    // Target pass-through on a plain op.
    run(ADD, 16'h1234, 16'h0000, 5'd5, 1'b1, 0, 16'h0000);
    tgt = 14'h2ABC;
    bus.target_in = tgt;
    @(posedge clk); #1;
    chk("target_out", 32'(bus.target_out), 32'(tgt));

    run(LOAD, 16'h0000, 16'h0042, 5'd3, 1'b1, 2, 16'hBEEF);
    run(STORE, 16'hA5A5, 16'h3FFF, 5'd7, 1'b0, 0, 16'h0000);
    run(LOAD, 16'h1111, 16'h0100, 5'd9, 1'b1, NEVER, 16'h0000);
    run(LOAD, 16'h0000, 16'h0200, 5'd10, 1'b1, 1, 16'hC0DE);
    run(STORE, 16'h5A5A, 16'h0010, 5'd1, 1'b0, 0, 16'h0000);
    run(LOAD, 16'h0000, 16'h0020, 5'd2, 1'b1, 0, 16'h7777);
    run(LOAD, 16'h0000, 16'h0030, 5'd4, 1'b1, int'(TO), 16'h4321);

    // Reset while an access is outstanding.
    @(posedge clk); #2;
    mon_en = 1'b0;
    @(negedge clk);
    bus.control_in = LOAD;
    bus.addr_in    = 16'h0055;
    bus.mem_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_wb_we", 32'(bus.wb_we), 32'd0);
    chk("midrst_mem_error", 32'(bus.mem_error), 32'd0);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.control_in = NOP;
    sb.delete();
    stall_cnt = 0;
    req_cnt   = 0;
    err_model = 1'b0;
    run(ADD, 16'h0F0F, 16'h0000, 5'd6, 1'b1, 0, 16'h0000);

    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2)      op = NOP;
      else if (sel < 5) op = 4'($urandom_range(1, 11));
      else if (sel < 8) op = LOAD;
      else              op = STORE;
      sel = $urandom_range(0, 19);
      if (sel < 14)      rdy = $urandom_range(0, 4);
      else if (sel < 16) rdy = int'(TO);
      else if (sel < 18) rdy = int'(TO) - 1;
      else               rdy = NEVER;
      run(op, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom), rdy, 16'($urandom));
    end

    @(posedge clk); #2;
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
